// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, load/store operation codes and the MEM-stage
// FSM state encoding for the MIPS32 MEM pipeline stage.
package mem_stage_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int ALU_OP_BUS   = 8;

  // Load/store operation codes (the 111x_xxxx group of the aluop space).
  localparam logic [ALU_OP_BUS-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALU_OP_BUS-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALU_OP_BUS-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALU_OP_BUS-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALU_OP_BUS-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALU_OP_BUS-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALU_OP_BUS-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALU_OP_BUS-1:0] EXE_SW_OP  = 8'b1110_1011;

  // A couple of non-memory codes, used for pass-through traffic.
  localparam logic [ALU_OP_BUS-1:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [ALU_OP_BUS-1:0] EXE_MTHI_OP = 8'b0001_0001;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational load/store lane logic.
// Inputs : aluop, addr_lo (effective address [1:0]), reg2 (store data),
//          rdata (bus read data).
// Outputs: is_mem / is_store op decode, misaligned flag, byte enables,
//          lane-replicated store data, sign/zero-extended load value.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [ALU_OP_BUS-1:0] aluop,
  input  logic [1:0]            addr_lo,
  input  logic [REG_BUS-1:0]    reg2,
  input  logic [REG_BUS-1:0]    rdata,
  output logic                  is_mem,
  output logic                  is_store,
  output logic                  misaligned,
  output logic [3:0]            be,
  output logic [REG_BUS-1:0]    wdata,
  output logic [REG_BUS-1:0]    ldata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = addr_lo[1] ? (addr_lo[0] ? rdata[31:24] : rdata[23:16])
                             : (addr_lo[0] ? rdata[15:8]  : rdata[7:0]);
  assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    is_mem     = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    be         = 4'b0000;
    wdata      = '0;
    ldata      = '0;

    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        is_mem = 1'b1;
        be     = 4'b0001 << addr_lo;
        wdata  = {4{reg2[7:0]}};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        is_mem     = 1'b1;
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{reg2[15:0]}};
      end
      EXE_LW_OP, EXE_SW_OP: begin
        is_mem     = 1'b1;
        misaligned = |addr_lo;
        be         = 4'b1111;
        wdata      = reg2;
      end
      default: ;
    endcase

    is_store = (aluop == EXE_SB_OP) || (aluop == EXE_SH_OP) || (aluop == EXE_SW_OP);

    case (aluop)
      EXE_LB_OP:  ldata = {{24{lane_b[7]}}, lane_b};
      EXE_LBU_OP: ldata = {24'h0, lane_b};
      EXE_LH_OP:  ldata = {{16{lane_h[15]}}, lane_h};
      EXE_LHU_OP: ldata = {16'h0, lane_h};
      EXE_LW_OP:  ldata = rdata;
      default:    ldata = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Non-memory ops pass ex_* to mem_*
// combinationally. Aligned loads/stores run a req/ack bus access through
// IDLE -> REQ -> DONE, holding the pipeline with stall_req until DONE.
// Misaligned accesses raise addr_err for one cycle and suppress writeback.
// Ports: clk/rst; ex_* from ex_mem; mem_* to mem_wb; stall_req, addr_err;
//        dbus_* request side (registered) and dbus_rdata/dbus_ack.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_BUS-1:0] ex_wd,
  input  logic                    ex_wreg,
  input  logic [REG_BUS-1:0]      ex_wdata,
  input  logic [ALU_OP_BUS-1:0]   ex_aluop,
  input  logic [REG_BUS-1:0]      ex_mem_addr,
  input  logic [REG_BUS-1:0]      ex_reg2,
  input  logic [REG_BUS-1:0]      ex_hi,
  input  logic [REG_BUS-1:0]      ex_lo,
  input  logic                    ex_enhilo,
  output logic [REG_ADDR_BUS-1:0] mem_wd,
  output logic                    mem_wreg,
  output logic [REG_BUS-1:0]      mem_wdata,
  output logic [REG_BUS-1:0]      mem_hi,
  output logic [REG_BUS-1:0]      mem_lo,
  output logic                    mem_enhilo,
  output logic                    stall_req,
  output logic                    addr_err,
  output logic                    dbus_req,
  output logic                    dbus_we,
  output logic [REG_BUS-1:0]      dbus_addr,
  output logic [3:0]              dbus_be,
  output logic [REG_BUS-1:0]      dbus_wdata,
  input  logic [REG_BUS-1:0]      dbus_rdata,
  input  logic                    dbus_ack
);

  mem_state_e                state_q, state_d;
  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [REG_BUS-1:0]        addr_q, addr_d;
  logic [3:0]                be_q, be_d;
  logic [REG_BUS-1:0]        wdata_q, wdata_d;
  logic [ALU_OP_BUS-1:0]     aluop_q, aluop_d;
  logic [1:0]                addr_lo_q, addr_lo_d;
  logic [REG_ADDR_BUS-1:0]   wd_q, wd_d;
  logic                      wreg_q, wreg_d;
  logic [REG_BUS-1:0]        rdata_q, rdata_d;

  // In IDLE the lane logic looks at the incoming instruction; afterwards it
  // looks at the latched op/offset and captured read data so DONE can
  // extract the load value while ex_* is still held.
  logic                      idle;
  logic [ALU_OP_BUS-1:0]     al_aluop;
  logic [1:0]                al_addr_lo;
  logic [REG_BUS-1:0]        al_rdata;
  logic                      al_is_mem, al_is_store, al_misaligned;
  logic [3:0]                al_be;
  logic [REG_BUS-1:0]        al_wdata, al_ldata;

  assign idle       = (state_q == MEM_IDLE);
  assign al_aluop   = idle ? ex_aluop          : aluop_q;
  assign al_addr_lo = idle ? ex_mem_addr[1:0]  : addr_lo_q;
  assign al_rdata   = idle ? dbus_rdata        : rdata_q;

  lsu_align u_align (
    .aluop      (al_aluop),
    .addr_lo    (al_addr_lo),
    .reg2       (ex_reg2),
    .rdata      (al_rdata),
    .is_mem     (al_is_mem),
    .is_store   (al_is_store),
    .misaligned (al_misaligned),
    .be         (al_be),
    .wdata      (al_wdata),
    .ldata      (al_ldata)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aluop_d   = aluop_q;
    addr_lo_d = addr_lo_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    rdata_d   = rdata_q;

    mem_wd     = ex_wd;
    mem_wreg   = ex_wreg;
    mem_wdata  = ex_wdata;
    mem_hi     = ex_hi;
    mem_lo     = ex_lo;
    mem_enhilo = ex_enhilo;
    stall_req  = 1'b0;
    addr_err   = 1'b0;

    case (state_q)
      MEM_IDLE: begin
        if (al_is_mem && al_misaligned) begin
          addr_err   = 1'b1;
          mem_wreg   = 1'b0;
          mem_enhilo = 1'b0;
        end else if (al_is_mem) begin
          stall_req  = 1'b1;
          mem_wd     = '0;
          mem_wreg   = 1'b0;
          mem_wdata  = '0;
          mem_hi     = '0;
          mem_lo     = '0;
          mem_enhilo = 1'b0;
          state_d    = MEM_REQ;
          req_d      = 1'b1;
          we_d       = al_is_store;
          addr_d     = {ex_mem_addr[31:2], 2'b00};
          be_d       = al_be;
          wdata_d    = al_wdata;
          aluop_d    = ex_aluop;
          addr_lo_d  = ex_mem_addr[1:0];
          wd_d       = ex_wd;
          wreg_d     = ex_wreg;
        end
      end
      MEM_REQ: begin
        stall_req  = 1'b1;
        mem_wd     = '0;
        mem_wreg   = 1'b0;
        mem_wdata  = '0;
        mem_hi     = '0;
        mem_lo     = '0;
        mem_enhilo = 1'b0;
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          req_d   = 1'b0;
          state_d = MEM_DONE;
        end
      end
      MEM_DONE: begin
        // ex_* still holds this instruction; hi/lo/enhilo pass through.
        mem_wd    = wd_q;
        mem_wreg  = wreg_q;
        mem_wdata = al_is_store ? ex_wdata : al_ldata;
        state_d   = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MEM_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      aluop_q   <= '0;
      addr_lo_q <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      aluop_q   <= aluop_d;
      addr_lo_q <= addr_lo_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      rdata_q   <= rdata_d;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;

endmodule
